// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module  : cache_controller (+ cache_controller_ctrl)
// Brief   : Direct-mapped write-back/write-allocate cache control path model
//           with tag/valid/dirty state and fixed-latency memory wait states.
// Revision: 1.0 - initial release
// ============================================================================

module cache_controller_ctrl #(
    parameter int MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic write_i,
    input  logic hit_i,
    input  logic victim_dirty_i,
    output logic latch_o,
    output logic set_dirty_o,
    output logic clean_victim_o,
    output logic fill_o,
    output logic ready_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMPARE    = 3'd1,
        ALLOCATE   = 3'd2,
        WRITE_BACK = 3'd3
    } state_t;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t           st;
    state_t           st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st    <= IDLE;
            cnt_q <= '0;
        end else begin
            st    <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d           = st;
        cnt_d          = cnt_q;
        latch_o        = 1'b0;
        set_dirty_o    = 1'b0;
        clean_victim_o = 1'b0;
        fill_o         = 1'b0;
        case (st)
            IDLE: begin
                if (req_i) begin
                    latch_o = 1'b1;
                    st_d    = COMPARE;
                end
            end
            COMPARE: begin
                if (hit_i) begin
                    set_dirty_o = write_i;
                    st_d        = IDLE;
                end else begin
                    // Counter is armed here so each wait state lasts exactly MEM_LATENCY cycles
                    cnt_d = C_CNT_LOAD;
                    st_d  = victim_dirty_i ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (cnt_q == '0) begin
                    clean_victim_o = 1'b1;
                    cnt_d          = C_CNT_LOAD;
                    st_d           = ALLOCATE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ALLOCATE: begin
                if (cnt_q == '0) begin
                    fill_o = 1'b1;
                    st_d   = COMPARE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign ready_o = (st == IDLE);

endmodule

module cache_controller #(
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        read,
    input  logic        write,
    output logic        ready
);

    localparam int TAG_BITS = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] index_q;
    logic [TAG_BITS-1:0]   tag_q;
    logic                  write_q;
    logic [TAG_BITS-1:0]   tags_q [LINES];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    logic w_latch;
    logic w_set_dirty;
    logic w_clean_victim;
    logic w_fill;
    logic w_hit;
    logic w_victim_dirty;
    logic w_unused_offset;

    assign w_hit           = valid_q[index_q] && (tags_q[index_q] == tag_q);
    assign w_victim_dirty  = valid_q[index_q] && dirty_q[index_q];
    assign w_unused_offset = ^addr[OFFSET_BITS-1:0];

    cache_controller_ctrl #(
        .MEM_LATENCY (MEM_LATENCY)
    ) control_unit (
        .clk            (clk),
        .rst            (rst),
        .req_i          (read | write),
        .write_i        (write_q),
        .hit_i          (w_hit),
        .victim_dirty_i (w_victim_dirty),
        .latch_o        (w_latch),
        .set_dirty_o    (w_set_dirty),
        .clean_victim_o (w_clean_victim),
        .fill_o         (w_fill),
        .ready_o        (ready)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            index_q <= '0;
            tag_q   <= '0;
            write_q <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (w_latch) begin
                index_q <= addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
                tag_q   <= addr[31:OFFSET_BITS+INDEX_BITS];
                write_q <= write;
            end
            if (w_set_dirty) begin
                dirty_q[index_q] <= 1'b1;
            end
            if (w_clean_victim) begin
                dirty_q[index_q] <= 1'b0;
            end
            if (w_fill) begin
                valid_q[index_q] <= 1'b1;
                dirty_q[index_q] <= 1'b0;
            end
        end
    end

    // Tags are meaningless while invalid, so they need no reset
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tags_q[index_q] <= tag_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_controller
// Brief   : Scoreboard bench for cache_controller against a line-state model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    localparam int OFFSET_BITS = 4;
    localparam int INDEX_BITS  = 4;
    localparam int MEM_LATENCY = 4;
    localparam int LINES       = 1 << INDEX_BITS;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic        read  = 1'b0;
    logic        write = 1'b0;
    logic        ready;
    logic [2:0]  st_probe;

    cache_controller #(
        .OFFSET_BITS (OFFSET_BITS),
        .INDEX_BITS  (INDEX_BITS),
        .MEM_LATENCY (MEM_LATENCY)
    ) cache (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .read  (read),
        .write (write),
        .ready (ready)
    );

    assign st_probe = cache.control_unit.st;

    always #5 clk = ~clk;

    typedef struct {
        int          low;
        int          wb;
        int          alloc;
        logic [31:0] a;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    int unsigned m_tag   [LINES];
    int          cur_low   = 0;
    int          cur_wb    = 0;
    int          cur_alloc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
    endfunction

    // Expected busy time follows from line state: hit=1, miss=2+M, dirty miss adds M
    function automatic exp_t predict(input logic [31:0] a, input bit wr);
        exp_t        e;
        int          idx;
        int unsigned tg;
        idx = int'((a >> OFFSET_BITS) % LINES);
        tg  = a >> (OFFSET_BITS + INDEX_BITS);
        e.a = a;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            e.low   = 1;
            e.wb    = 0;
            e.alloc = 0;
            if (wr) m_dirty[idx] = 1'b1;
        end else begin
            e.wb         = (m_valid[idx] && m_dirty[idx]) ? MEM_LATENCY : 0;
            e.alloc      = MEM_LATENCY;
            e.low        = 2 + e.alloc + e.wb;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = wr;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            cur_low   = 0;
            cur_wb    = 0;
            cur_alloc = 0;
        end else begin
            check("ready_vs_state", int'(ready), int'(st_probe == 3'd0));
            check("state_range", int'(st_probe < 3'd4), 1);
            if (!ready) begin
                cur_low++;
                if (st_probe == 3'd3) cur_wb++;
                if (st_probe == 3'd2) cur_alloc++;
            end else if (cur_low > 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_txn", cur_low, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("busy_cycles@%h", e.a), cur_low, e.low);
                    check($sformatf("writeback_cycles@%h", e.a), cur_wb, e.wb);
                    check($sformatf("allocate_cycles@%h", e.a), cur_alloc, e.alloc);
                end
                cur_low   = 0;
                cur_wb    = 0;
                cur_alloc = 0;
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk); #1;
        while (!ready && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_st(input logic [2:0] s);
        int k;
        k = 0;
        @(negedge clk); #1;
        while (st_probe != s && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        if (st_probe != s) check("state_timeout", int'(st_probe), int'(s));
    endtask

    task automatic issue(input logic [31:0] a, input bit rd, input bit wr);
        wait_ready();
        addr  = a;
        read  = rd;
        write = wr;
        if (rd || wr) sb.push_back(predict(a, wr));
        @(posedge clk); #1;
        read  = 1'b0;
        write = 1'b0;
        addr  = $urandom;
    endtask

    initial begin
        model_clear();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("reset_state", int'(st_probe), 0);
        check("reset_ready", int'(ready), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("post_reset_ready", int'(ready), 1);

        issue(32'h10, 1'b1, 1'b0);
        issue(32'h10, 1'b1, 1'b0);
        issue(32'h20, 1'b0, 1'b1);
        issue(32'h220, 1'b1, 1'b0);
        issue(32'h20, 1'b1, 1'b0);
        issue(32'h100, 1'b1, 1'b0);
        issue(32'h200, 1'b0, 1'b1);
        issue(32'h100, 1'b1, 1'b0);

        // Write strobe raised while busy must be dropped
        issue(32'h40, 1'b1, 1'b0);
        wait_st(3'd2);
        addr  = 32'h30;
        write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        issue(32'h30, 1'b1, 1'b0);

        // Reset during ALLOCATE aborts the transaction and flushes all lines
        issue(32'h50, 1'b1, 1'b0);
        wait_st(3'd2);
        rst = 1'b0;
        sb.delete();
        model_clear();
        @(posedge clk);
        @(negedge clk); #1;
        check("midop_reset_state", int'(st_probe), 0);
        check("midop_reset_ready", int'(ready), 1);
        rst = 1'b1;
        issue(32'h10, 1'b1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          op;
            a  = ($urandom_range(0, 3) << (OFFSET_BITS + INDEX_BITS))
               | ($urandom_range(0, 3) << OFFSET_BITS)
               | $urandom_range(0, 15);
            op = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, op != 1, op != 0);
        end

        wait_ready();
        @(negedge clk); #1;
        check("scoreboard_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
